act_pio_sequencer: RTL

- Sequences sigmoid and inverse-sigmoid requests from the two SoC PIO command ports onto one shared, multi-cycle activation unit.
- Returns each result on the matching PIO response port.
- Uses a bit-31 toggle handshake, so software can issue and poll requests over plain PIO registers.
- Sits in the top level, between the SoC's to_sig/to_isig hw-facing outputs and sw-facing inputs.

---
 rtl/act_pio_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/act_pio_sequencer.sv
//------------------------------------------------------------------------------
// Module      : act_pio_sequencer
// Description : Arbitrates sigmoid / inverse-sigmoid PIO toggle requests onto
//               one shared multi-cycle activation unit and returns the results.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module act_pio_sequencer #(
    parameter int DATA_W      = 31,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 11
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [31:0]       sig_cmd_in,
    input  logic [31:0]       isig_cmd_in,
    output logic [31:0]       sig_rsp_out,
    output logic [31:0]       isig_rsp_out,
    output logic              act_start,
    output logic              act_mode,
    output logic [DATA_W-1:0] act_operand,
    input  logic              act_done,
    input  logic [DATA_W-1:0] act_result,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT      = 2'd2,
        S_WRITEBACK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state_q,       state_d;
    logic [31:0]       sig_cmd_q,     sig_cmd_d;
    logic [31:0]       isig_cmd_q,    isig_cmd_d;
    logic [31:0]       sig_rsp_q,     sig_rsp_d;
    logic [31:0]       isig_rsp_q,    isig_rsp_d;
    logic              act_start_q,   act_start_d;
    logic              act_mode_q,    act_mode_d;
    logic [DATA_W-1:0] act_operand_q, act_operand_d;
    logic [DATA_W-1:0] result_q,      result_d;
    logic              tog_q,         tog_d;
    logic              rr_q,          rr_d;
    logic [CNT_W-1:0]  cnt_q,         cnt_d;
    logic              timeout_err_q, timeout_err_d;

    logic              sig_pend;
    logic              isig_pend;
    logic              grant_isig;
    logic [31:0]       wb_word;
    logic              unused_cmd_bits;

    // act_mode_q doubles as the in-flight channel id (0 = sig, 1 = isig).
    always_comb begin
        state_d       = state_q;
        sig_cmd_d     = sig_cmd_in;
        isig_cmd_d    = isig_cmd_in;
        sig_rsp_d     = sig_rsp_q;
        isig_rsp_d    = isig_rsp_q;
        act_start_d   = 1'b0;
        act_mode_d    = act_mode_q;
        act_operand_d = act_operand_q;
        result_d      = result_q;
        tog_d         = tog_q;
        rr_d          = rr_q;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;

        sig_pend   = sig_cmd_q[31]  ^ sig_rsp_q[31];
        isig_pend  = isig_cmd_q[31] ^ isig_rsp_q[31];
        grant_isig = (sig_pend && isig_pend) ? ~rr_q : isig_pend;

        wb_word             = '0;
        wb_word[DATA_W-1:0] = result_q;
        wb_word[31]         = tog_q;

        case (state_q)
            S_IDLE: begin
                if (sig_pend || isig_pend) begin
                    act_mode_d    = grant_isig;
                    tog_d         = grant_isig ? isig_cmd_q[31] : sig_cmd_q[31];
                    act_operand_d = grant_isig ? isig_cmd_q[DATA_W-1:0]
                                               : sig_cmd_q[DATA_W-1:0];
                    act_start_d   = 1'b1;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion arriving on the last allowed cycle still counts.
                if (act_done) begin
                    result_d = act_result;
                    state_d  = S_WRITEBACK;
                end else if (cnt_q == CNT_LAST) begin
                    result_d      = '1;
                    timeout_err_d = 1'b1;
                    state_d       = S_WRITEBACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WRITEBACK: begin
                if (act_mode_q) isig_rsp_d = wb_word;
                else            sig_rsp_d  = wb_word;
                rr_d    = act_mode_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q       <= S_IDLE;
            sig_cmd_q     <= '0;
            isig_cmd_q    <= '0;
            sig_rsp_q     <= '0;
            isig_rsp_q    <= '0;
            act_start_q   <= 1'b0;
            act_mode_q    <= 1'b0;
            act_operand_q <= '0;
            result_q      <= '0;
            tog_q         <= 1'b0;
            rr_q          <= 1'b0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sig_cmd_q     <= sig_cmd_d;
            isig_cmd_q    <= isig_cmd_d;
            sig_rsp_q     <= sig_rsp_d;
            isig_rsp_q    <= isig_rsp_d;
            act_start_q   <= act_start_d;
            act_mode_q    <= act_mode_d;
            act_operand_q <= act_operand_d;
            result_q      <= result_d;
            tog_q         <= tog_d;
            rr_q          <= rr_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign unused_cmd_bits = ^{sig_cmd_q, isig_cmd_q};

    assign sig_rsp_out  = sig_rsp_q;
    assign isig_rsp_out = isig_rsp_q;
    assign act_start    = act_start_q;
    assign act_mode     = act_mode_q;
    assign act_operand  = act_operand_q;
    assign busy         = (state_q != S_IDLE);
    assign timeout_err  = timeout_err_q;

endmodule

`default_nettype wire
